alu_residue_checker: RTL and testbench

Receiver/checker for the mod-31 residue the simple ALU emits alongside its result. It accepts a 32-bit result, the ALU-predicted 5-bit residue and a tag, then recomputes the residue of the result by iterative 5-bit end-around folding. It compares the two and reports match or mismatch per tag. It sits on the execute-stage writeback path and keeps a saturating error count for the fault-detection logic.

---
 rtl/alu_residue_checker_pkg.sv | 20 ++
 rtl/alu_residue_checker_mod31_fold_add.sv | 16 +
 rtl/alu_residue_checker.sv | 184 ++++++++++++++++++
 tb/tb_alu_residue_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_residue_checker_pkg.sv
// rtl/alu_residue_checker_pkg.sv - shared constants, state encoding and mod-31 normalization
package alu_residue_checker_pkg;

  localparam int SIZE_DATA  = 32;
  localparam int SIZE_MOD   = 5;
  localparam int NUM_CHUNKS = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_CMP  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // 31 and 0 are both encodings of zero in a mod-31 residue
  function automatic logic [SIZE_MOD-1:0] norm_mod31(input logic [SIZE_MOD-1:0] v);
    return (v == 5'd31) ? '0 : v;
  endfunction

endpackage

// File: rtl/alu_residue_checker_mod31_fold_add.sv
// rtl/alu_residue_checker_mod31_fold_add.sv - combinational 5+5->5 end-around-carry adder (mod 31)
module mod31_fold_add
  import alu_residue_checker_pkg::*;
(
  input  logic [SIZE_MOD-1:0] a_i,
  input  logic [SIZE_MOD-1:0] b_i,
  output logic [SIZE_MOD-1:0] sum_o
);

  logic [SIZE_MOD:0] sum;

  // when the carry is set the low bits are at most 30, so adding it back cannot overflow
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = sum[SIZE_MOD-1:0] + {{(SIZE_MOD-1){1'b0}}, sum[SIZE_MOD]};

endmodule

// File: rtl/alu_residue_checker.sv
// rtl/alu_residue_checker.sv - recomputes the mod-31 residue of an ALU result and checks it per tag
module alu_residue_checker
  import alu_residue_checker_pkg::*;
#(
  parameter int TAG_W            = 7,
  parameter int CHUNKS_PER_CYCLE = 1,
  parameter int ERR_CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [SIZE_DATA-1:0] result_i,
  input  logic [SIZE_MOD-1:0]  pred_mod_i,
  input  logic                 pred_valid_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic                 flush_i,
  output logic                 done_valid_o,
  input  logic                 ready_i,
  output logic [TAG_W-1:0]     done_tag_o,
  output logic                 err_o,
  output logic [SIZE_MOD-1:0]  calc_mod_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  input  logic                 err_clr_i
);

  localparam logic [3:0] STEP = 4'(CHUNKS_PER_CYCLE);
  localparam logic [3:0] LAST = 4'(NUM_CHUNKS);

  state_e               state_q, state_d;
  logic [SIZE_DATA-1:0] data_q, data_d;
  logic [SIZE_MOD-1:0]  pred_q, pred_d;
  logic                 pv_q, pv_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [SIZE_MOD-1:0]  acc_q, acc_d;
  logic [3:0]           idx_q, idx_d;
  logic                 done_valid_q, done_valid_d;
  logic [TAG_W-1:0]     done_tag_q, done_tag_d;
  logic                 err_q, err_d;
  logic [SIZE_MOD-1:0]  calc_q, calc_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic [SIZE_MOD-1:0]  chunks [8];
  logic [SIZE_MOD-1:0]  chain [CHUNKS_PER_CYCLE+1];
  logic [3:0]           idx_next;
  logic [SIZE_MOD-1:0]  acc_norm;
  logic                 cmp_err;
  logic                 cnt_inc;
  logic                 accept;

  // slot 7 is a zero chunk so a partial last group folds in nothing
  for (genvar k = 0; k < NUM_CHUNKS-1; k++) begin : g_chunk
    assign chunks[k] = data_q[SIZE_MOD*k +: SIZE_MOD];
  end
  assign chunks[6] = {3'b000, data_q[SIZE_DATA-1:SIZE_DATA-2]};
  assign chunks[7] = '0;

  assign chain[0] = acc_q;
  for (genvar g = 0; g < CHUNKS_PER_CYCLE; g++) begin : g_fold
    mod31_fold_add u_fold_add (
      .a_i   (chain[g]),
      .b_i   (chunks[idx_q[2:0] + 3'(g)]),
      .sum_o (chain[g+1])
    );
  end

  assign idx_next = idx_q + STEP;
  assign acc_norm = norm_mod31(acc_q);
  assign cmp_err  = pv_q & (acc_norm != norm_mod31(pred_q));

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    pred_d       = pred_q;
    pv_d         = pv_q;
    tag_d        = tag_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    done_valid_d = done_valid_q;
    done_tag_d   = done_tag_q;
    err_d        = err_q;
    calc_d       = calc_q;
    cnt_inc      = 1'b0;
    ready_o      = 1'b0;
    accept       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        accept  = valid_i & ~flush_i;
      end
      ST_FOLD: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = chain[CHUNKS_PER_CYCLE];
          idx_d = idx_next;
          if (idx_next >= LAST) state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          calc_d       = acc_norm;
          err_d        = cmp_err;
          done_tag_d   = tag_q;
          done_valid_d = 1'b1;
          cnt_inc      = cmp_err;
          state_d      = ST_OUT;
        end
      end
      ST_OUT: begin
        ready_o = ready_i;
        if (flush_i) begin
          done_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else if (ready_i) begin
          done_valid_d = 1'b0;
          state_d      = ST_IDLE;
          accept       = valid_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      data_d  = result_i;
      pred_d  = pred_mod_i;
      pv_d    = pred_valid_i;
      tag_d   = tag_i;
      acc_d   = '0;
      idx_d   = '0;
      state_d = ST_FOLD;
    end
  end

  // a clear coinciding with an increment still records that one error
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i) begin
      cnt_d = cnt_inc ? ERR_CNT_W'(1) : '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      pred_q       <= '0;
      pv_q         <= 1'b0;
      tag_q        <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      err_q        <= 1'b0;
      calc_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      pred_q       <= pred_d;
      pv_q         <= pv_d;
      tag_q        <= tag_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      err_q        <= err_d;
      calc_q       <= calc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign done_valid_o = done_valid_q;
  assign done_tag_o   = done_tag_q;
  assign err_o        = err_q;
  assign calc_mod_o   = calc_q;
  assign err_count_o  = cnt_q;

endmodule

// File: tb/tb_alu_residue_checker.sv
// tb/tb_alu_residue_checker.sv - randomized self-checking bench against a plain-arithmetic mod-31 model
module tb_alu_residue_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        valid, rdy_o, pv, flush, dv, rdy_i, err, clr;
  logic [31:0] result;
  logic [4:0]  pred, calc;
  logic [6:0]  tag, dtag;
  logic [15:0] cnt;

  logic        s_valid, s_rdy_o, s_pv, s_flush, s_dv, s_rdy_i, s_err, s_clr;
  logic [31:0] s_result;
  logic [4:0]  s_pred, s_calc;
  logic [6:0]  s_tag, s_dtag;
  logic [3:0]  s_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  int s_exp_cnt = 0;

  alu_residue_checker dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid), .ready_o(rdy_o),
    .result_i(result), .pred_mod_i(pred), .pred_valid_i(pv), .tag_i(tag),
    .flush_i(flush), .done_valid_o(dv), .ready_i(rdy_i), .done_tag_o(dtag),
    .err_o(err), .calc_mod_o(calc), .err_count_o(cnt), .err_clr_i(clr)
  );

  alu_residue_checker #(.TAG_W(7), .CHUNKS_PER_CYCLE(7), .ERR_CNT_W(4)) dut_fast (
    .clk(clk), .reset_n(reset_n), .valid_i(s_valid), .ready_o(s_rdy_o),
    .result_i(s_result), .pred_mod_i(s_pred), .pred_valid_i(s_pv), .tag_i(s_tag),
    .flush_i(s_flush), .done_valid_o(s_dv), .ready_i(s_rdy_i), .done_tag_o(s_dtag),
    .err_o(s_err), .calc_mod_o(s_calc), .err_count_o(s_cnt), .err_clr_i(s_clr)
  );

  function automatic int ref_res(input logic [31:0] r);
    return int'(r % 32'd31);
  endfunction

  function automatic bit ref_err(input logic [31:0] r, input logic [4:0] p, input bit v);
    return v && (ref_res(r) != (int'(p) % 31));
  endfunction

  task automatic start(input logic [31:0] r, input logic [4:0] p, input logic v, input logic [6:0] t);
    valid = 1'b1; result = r; pred = p; pv = v; tag = t;
    @(negedge clk);
    valid = 1'b0; rdy_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (dv !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
  endtask

  task automatic s_start(input logic [31:0] r, input logic [4:0] p, input logic v, input logic [6:0] t);
    s_valid = 1'b1; s_result = r; s_pred = p; s_pv = v; s_tag = t;
    @(negedge clk);
    s_valid = 1'b0; s_rdy_i = 1'b0;
  endtask

  task automatic s_wait_done(output int cyc);
    cyc = 0;
    while (s_dv !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; valid = 1'b1; s_valid = 1'b1;
    result = 32'hDEAD_BEEF; s_result = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    vectors++; if (rdy_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", rdy_o); end
    vectors++; if (dv !== 1'b0) begin miscompares++; $display("FAIL reset_done_valid: got %b want 0", dv); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (calc !== 5'd0) begin miscompares++; $display("FAIL reset_calc: got %0d want 0", calc); end
    vectors++; if (dtag !== 7'd0) begin miscompares++; $display("FAIL reset_tag: got %0d want 0", dtag); end
    vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", cnt); end
    vectors++; if (s_rdy_o !== 1'b1 || s_dv !== 1'b0 || s_cnt !== 4'd0) begin
      miscompares++; $display("FAIL reset_fast: got ready=%b dv=%b cnt=%0d want 1 0 0", s_rdy_o, s_dv, s_cnt);
    end
    valid = 1'b0; s_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] rv [5];
    logic [4:0]  pt [5];
    int cyc;
    bit er;
    rv[0] = 32'h0000_0020; pt[0] = 5'd1;
    rv[1] = 32'hFFFF_FFFF; pt[1] = 5'd3;
    rv[2] = 32'hFFFF_FFFF; pt[2] = 5'd31;
    rv[3] = 32'h0000_003E; pt[3] = 5'd31;
    rv[4] = 32'h0000_0000; pt[4] = 5'd0;
    for (int i = 0; i < 5; i++) begin
      start(rv[i], pt[i], 1'b1, 7'(i + 10));
      wait_done(cyc);
      er = ref_err(rv[i], pt[i], 1'b1);
      if (er) exp_cnt++;
      vectors++; if (cyc != 8) begin miscompares++; $display("FAIL basic_latency[%0d]: got %0d want 8", i, cyc); end
      vectors++; if (calc !== 5'(ref_res(rv[i]))) begin miscompares++; $display("FAIL basic_calc[%0d]: got %0d want %0d", i, calc, ref_res(rv[i])); end
      vectors++; if (err !== er) begin miscompares++; $display("FAIL basic_err[%0d]: got %b want %b", i, err, er); end
      vectors++; if (dtag !== 7'(i + 10)) begin miscompares++; $display("FAIL basic_tag[%0d]: got %0d want %0d", i, dtag, i + 10); end
      vectors++; if (cnt !== 16'(exp_cnt)) begin miscompares++; $display("FAIL basic_count[%0d]: got %0d want %0d", i, cnt, exp_cnt); end
      consume();
      vectors++; if (dv !== 1'b0) begin miscompares++; $display("FAIL basic_drop[%0d]: got %b want 0", i, dv); end
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [4:0]  p;
    logic [6:0]  t;
    logic        v;
    int cyc, res;
    bit er;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      res = ref_res(r);
      case ($urandom_range(0, 3))
        0: p = 5'(res);
        1: p = (res == 0) ? 5'd31 : 5'(res);
        default: p = 5'($urandom_range(0, 31));
      endcase
      v = ($urandom_range(0, 4) != 0);
      t = 7'($urandom);
      start(r, p, v, t);
      wait_done(cyc);
      er = ref_err(r, p, v);
      if (er) exp_cnt++;
      vectors++; if (cyc != 8) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want 8", i, cyc); end
      vectors++; if (calc !== 5'(res)) begin miscompares++; $display("FAIL rand_calc[%0d]: r=%h got %0d want %0d", i, r, calc, res); end
      vectors++; if (err !== er) begin miscompares++; $display("FAIL rand_err[%0d]: r=%h p=%0d v=%b got %b want %b", i, r, p, v, err, er); end
      vectors++; if (dtag !== t) begin miscompares++; $display("FAIL rand_tag[%0d]: got %0d want %0d", i, dtag, t); end
      vectors++; if (cnt !== 16'(exp_cnt)) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, cnt, exp_cnt); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      vectors++; if (dv !== 1'b1) begin miscompares++; $display("FAIL rand_hold[%0d]: got %b want 1", i, dv); end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit er;
    start(32'h1234_5678, 5'd7, 1'b1, 7'h55);
    wait_done(cyc);
    er = ref_err(32'h1234_5678, 5'd7, 1'b1);
    if (er) exp_cnt++;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (dv !== 1'b1 || rdy_o !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got dv=%b ready=%b want 1 0", i, dv, rdy_o);
      end
      vectors++; if (calc !== 5'(ref_res(32'h1234_5678)) || err !== er || dtag !== 7'h55) begin
        miscompares++; $display("FAIL bp_stable[%0d]: got calc=%0d err=%b tag=%h want %0d %b 55", i, calc, err, dtag, ref_res(32'h1234_5678), er);
      end
      @(negedge clk);
    end
    rdy_i = 1'b1;
    #1;
    vectors++; if (rdy_o !== 1'b1) begin miscompares++; $display("FAIL bp_ready_pass: got %b want 1", rdy_o); end
    start(32'hCAFE_F00D, 5'd0, 1'b1, 7'h2A);
    wait_done(cyc);
    er = ref_err(32'hCAFE_F00D, 5'd0, 1'b1);
    if (er) exp_cnt++;
    vectors++; if (cyc != 8) begin miscompares++; $display("FAIL b2b_latency: got %0d want 8", cyc); end
    vectors++; if (calc !== 5'(ref_res(32'hCAFE_F00D)) || err !== er || dtag !== 7'h2A) begin
      miscompares++; $display("FAIL b2b_result: got calc=%0d err=%b tag=%h want %0d %b 2a", calc, err, dtag, ref_res(32'hCAFE_F00D), er);
    end
    vectors++; if (cnt !== 16'(exp_cnt)) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", cnt, exp_cnt); end
    consume();
  endtask

  task automatic test_flush();
    int cyc;
    start(32'h0000_0040, 5'd5, 1'b1, 7'h11);
    repeat (3) @(negedge clk);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    wait_done(cyc);
    vectors++; if (dv !== 1'b0) begin miscompares++; $display("FAIL flush_fold: got dv=%b want 0", dv); end
    vectors++; if (rdy_o !== 1'b1 || cnt !== 16'(exp_cnt)) begin
      miscompares++; $display("FAIL flush_fold_state: got ready=%b cnt=%0d want 1 %0d", rdy_o, cnt, exp_cnt);
    end

    start(32'h0000_0040, 5'd5, 1'b1, 7'h12);
    repeat (7) @(negedge clk);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    wait_done(cyc);
    vectors++; if (dv !== 1'b0 || cnt !== 16'(exp_cnt)) begin
      miscompares++; $display("FAIL flush_cmp: got dv=%b cnt=%0d want 0 %0d", dv, cnt, exp_cnt);
    end

    valid = 1'b1; flush = 1'b1; result = 32'h0000_0040; pred = 5'd5; pv = 1'b1; tag = 7'h13;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    wait_done(cyc);
    vectors++; if (dv !== 1'b0) begin miscompares++; $display("FAIL flush_idle_drop: got dv=%b want 0", dv); end

    start(32'h0000_0040, 5'd5, 1'b1, 7'h14);
    wait_done(cyc);
    exp_cnt++;
    vectors++; if (dv !== 1'b1 || err !== 1'b1 || cnt !== 16'(exp_cnt)) begin
      miscompares++; $display("FAIL flush_out_pre: got dv=%b err=%b cnt=%0d want 1 1 %0d", dv, err, cnt, exp_cnt);
    end
    valid = 1'b1; rdy_i = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; rdy_i = 1'b0; flush = 1'b0;
    vectors++; if (dv !== 1'b0 || rdy_o !== 1'b1 || cnt !== 16'(exp_cnt)) begin
      miscompares++; $display("FAIL flush_out: got dv=%b ready=%b cnt=%0d want 0 1 %0d", dv, rdy_o, cnt, exp_cnt);
    end
    wait_done(cyc);
    vectors++; if (dv !== 1'b0) begin miscompares++; $display("FAIL flush_out_drop: got dv=%b want 0", dv); end

    start(32'h0000_0040, 5'd5, 1'b0, 7'h15);
    wait_done(cyc);
    vectors++; if (err !== 1'b0 || calc !== 5'd2 || cnt !== 16'(exp_cnt)) begin
      miscompares++; $display("FAIL nopred: got err=%b calc=%0d cnt=%0d want 0 2 %0d", err, calc, cnt, exp_cnt);
    end
    consume();
  endtask

  task automatic test_counter();
    logic [31:0] r;
    logic [4:0]  p;
    int cyc, res;
    for (int i = 0; i < 17; i++) begin
      r = $urandom;
      res = ref_res(r);
      p = 5'((res + 1 + int'($urandom_range(0, 29))) % 31);
      s_start(r, p, 1'b1, 7'(i));
      s_wait_done(cyc);
      if (s_exp_cnt < 15) s_exp_cnt++;
      vectors++; if (cyc != 2) begin miscompares++; $display("FAIL fast_latency[%0d]: got %0d want 2", i, cyc); end
      vectors++; if (s_calc !== 5'(res) || s_err !== 1'b1) begin
        miscompares++; $display("FAIL fast_result[%0d]: got calc=%0d err=%b want %0d 1", i, s_calc, s_err, res);
      end
      vectors++; if (s_cnt !== 4'(s_exp_cnt)) begin miscompares++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, s_cnt, s_exp_cnt); end
      s_rdy_i = 1'b1; @(negedge clk); s_rdy_i = 1'b0;
    end
    s_start(32'h0000_0001, 5'd9, 1'b1, 7'h7F);
    @(negedge clk);
    s_clr = 1'b1; @(negedge clk); s_clr = 1'b0;
    vectors++; if (s_dv !== 1'b1 || s_cnt !== 4'd1) begin
      miscompares++; $display("FAIL clr_with_inc: got dv=%b cnt=%0d want 1 1", s_dv, s_cnt);
    end
    s_rdy_i = 1'b1; @(negedge clk); s_rdy_i = 1'b0;
    s_clr = 1'b1; @(negedge clk); s_clr = 1'b0;
    vectors++; if (s_cnt !== 4'd0) begin miscompares++; $display("FAIL clr_plain: got %0d want 0", s_cnt); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    start(32'h0000_0040, 5'd5, 1'b1, 7'h21);
    repeat (4) @(negedge clk);
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    exp_cnt = 0;
    vectors++; if (dv !== 1'b0 || rdy_o !== 1'b1 || cnt !== 16'd0) begin
      miscompares++; $display("FAIL reset_mid: got dv=%b ready=%b cnt=%0d want 0 1 0", dv, rdy_o, cnt);
    end
    wait_done(cyc);
    vectors++; if (dv !== 1'b0) begin miscompares++; $display("FAIL reset_mid_drop: got dv=%b want 0", dv); end
  endtask

  initial begin
    reset_n = 1'b0;
    valid = 1'b0; pv = 1'b0; flush = 1'b0; rdy_i = 1'b0; clr = 1'b0;
    result = '0; pred = '0; tag = '0;
    s_valid = 1'b0; s_pv = 1'b0; s_flush = 1'b0; s_rdy_i = 1'b0; s_clr = 1'b0;
    s_result = '0; s_pred = '0; s_tag = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_flush();
    test_counter();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
